// File: rtl/rom_reader_pkg.sv
// rtl/rom_reader_pkg.sv - shared types, defaults and sizing helper for the ROM read controller
package rom_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_RECOVER = 2'd2
   } rom_state_t;

   localparam int DEFAULT_WAIT_CYCLES     = 8;
   localparam int DEFAULT_RECOVERY_CYCLES = 1;

   // Wide enough to hold the larger of the two reload values (max - 1).
   function automatic int cnt_width(input int wait_cycles, input int recovery_cycles);
      int m;
      m = 2;
      if (wait_cycles > m)
         m = wait_cycles;
      if (recovery_cycles > m)
         m = recovery_cycles;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/rom_wait_timer.sv
// rtl/rom_wait_timer.sv - loadable down-counter shared by the access and recovery countdowns
module rom_wait_timer #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   // Counts down and parks at zero until the next load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (load)
         count <= load_value;
      else if (count != '0)
         count <= count - 1'b1;
   end

   assign zero = (count == '0);

endmodule

// File: rtl/rom_async_reader.sv
// rtl/rom_async_reader.sv - read controller for an asynchronous 27xxx-style ROM; ROM_READER_CACHE_EN adds a one-entry last-word cache
module rom_async_reader
   import rom_reader_pkg::*;
#(
   parameter int DATA_WIDTH      = 8,
   parameter int ADDR_WIDTH      = 15,
   parameter int WAIT_CYCLES     = DEFAULT_WAIT_CYCLES,
   parameter int RECOVERY_CYCLES = DEFAULT_RECOVERY_CYCLES
) (
   input  logic                  clk,
   input  logic                  RSTn,
   input  logic                  REQ,
   input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
   output logic                  BUSY,
   output logic                  DVALID,
   output logic [DATA_WIDTH-1:0] DOUT,
   output logic [ADDR_WIDTH-1:0] ROM_ADDR,
   output logic                  ROM_CEn,
   output logic                  ROM_OEn,
   input  logic [DATA_WIDTH-1:0] ROM_DATA
);

   localparam int CW = cnt_width(WAIT_CYCLES, RECOVERY_CYCLES);
   localparam logic [CW-1:0] WAIT_LOAD    = CW'(WAIT_CYCLES - 1);
   localparam logic [CW-1:0] RECOVER_LOAD = CW'((RECOVERY_CYCLES > 0) ? RECOVERY_CYCLES - 1 : 0);
   localparam bit HAS_RECOVERY = (RECOVERY_CYCLES > 0);

   rom_state_t      state;
   logic            tmr_load;
   logic [CW-1:0]   tmr_value;
   logic            tmr_zero;
   logic            hit;
   logic [DATA_WIDTH-1:0] hit_data;

`ifdef ROM_READER_CACHE_EN
   logic [ADDR_WIDTH-1:0] cache_tag;
   logic [DATA_WIDTH-1:0] cache_data;
   logic                  cache_valid;

   // Refilled on every completed bus read; invalidated only by reset.
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         cache_tag   <= '0;
         cache_data  <= '0;
         cache_valid <= 1'b0;
      end else if (state == ST_ACCESS && tmr_zero) begin
         cache_tag   <= ROM_ADDR;
         cache_data  <= ROM_DATA;
         cache_valid <= 1'b1;
      end
   end

   assign hit      = cache_valid && (REQ_ADDR == cache_tag);
   assign hit_data = cache_data;
`else
   assign hit      = 1'b0;
   assign hit_data = '0;
`endif

   always_comb begin
      tmr_load  = 1'b0;
      tmr_value = WAIT_LOAD;
      case (state)
         ST_IDLE: begin
            if (REQ && !hit)
               tmr_load = 1'b1;
         end
         ST_ACCESS: begin
            if (tmr_zero && HAS_RECOVERY) begin
               tmr_load  = 1'b1;
               tmr_value = RECOVER_LOAD;
            end
         end
         default: ;
      endcase
   end

   rom_wait_timer #(
      .WIDTH (CW)
   ) u_timer (
      .clk        (clk),
      .rst_n      (RSTn),
      .load       (tmr_load),
      .load_value (tmr_value),
      .zero       (tmr_zero)
   );

   // ROM_ADDR only moves on the accepting edge, so it is stable while strobes are low.
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         state    <= ST_IDLE;
         BUSY     <= 1'b0;
         DVALID   <= 1'b0;
         DOUT     <= '0;
         ROM_ADDR <= '0;
         ROM_CEn  <= 1'b1;
         ROM_OEn  <= 1'b1;
      end else begin
         DVALID <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (REQ) begin
                  if (hit) begin
                     DOUT   <= hit_data;
                     DVALID <= 1'b1;
                  end else begin
                     ROM_ADDR <= REQ_ADDR;
                     ROM_CEn  <= 1'b0;
                     ROM_OEn  <= 1'b0;
                     BUSY     <= 1'b1;
                     state    <= ST_ACCESS;
                  end
               end
            end
            ST_ACCESS: begin
               if (tmr_zero) begin
                  DOUT    <= ROM_DATA;
                  DVALID  <= 1'b1;
                  ROM_CEn <= 1'b1;
                  ROM_OEn <= 1'b1;
                  if (HAS_RECOVERY) begin
                     state <= ST_RECOVER;
                  end else begin
                     BUSY  <= 1'b0;
                     state <= ST_IDLE;
                  end
               end
            end
            ST_RECOVER: begin
               if (tmr_zero) begin
                  BUSY  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: begin
               BUSY    <= 1'b0;
               ROM_CEn <= 1'b1;
               ROM_OEn <= 1'b1;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rom_async_reader.sv
// tb/tb_rom_async_reader.sv - scoreboard bench for rom_async_reader with a behavioural ROM
module tb_rom_async_reader;

   logic        clk;
   logic        RSTn;
   logic        REQ;
   logic [14:0] REQ_ADDR;
   logic        BUSY;
   logic        DVALID;
   logic [7:0]  DOUT;
   logic [14:0] ROM_ADDR;
   logic        ROM_CEn;
   logic        ROM_OEn;
   wire  [7:0]  rom_data;

   int checks = 0;
   int failures = 0;
   int dv_count = 0;
   logic [7:0] exp_q[$];

   rom_async_reader #(
      .DATA_WIDTH      (8),
      .ADDR_WIDTH      (15),
      .WAIT_CYCLES     (4),
      .RECOVERY_CYCLES (1)
   ) dut (
      .clk      (clk),
      .RSTn     (RSTn),
      .REQ      (REQ),
      .REQ_ADDR (REQ_ADDR),
      .BUSY     (BUSY),
      .DVALID   (DVALID),
      .DOUT     (DOUT),
      .ROM_ADDR (ROM_ADDR),
      .ROM_CEn  (ROM_CEn),
      .ROM_OEn  (ROM_OEn),
      .ROM_DATA (rom_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] rom_word(input logic [14:0] a);
      case (a)
         15'h1234: rom_word = 8'hA5;
         15'h0001: rom_word = 8'h11;
         15'h0002: rom_word = 8'h22;
         15'h1000: rom_word = 8'h3C;
         15'h0100: rom_word = 8'h5A;
         15'h0101: rom_word = 8'hC3;
         default:  rom_word = 8'hEE;
      endcase
   endfunction

   assign rom_data = (!ROM_CEn && !ROM_OEn) ? rom_word(ROM_ADDR) : 8'hzz;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: every DVALID pops one expected word.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (RSTn === 1'b1 && DVALID === 1'b1) begin
            dv_count++;
            if (exp_q.size() == 0) begin
               check("unexpected_dvalid", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("dout", {24'd0, DOUT}, {24'd0, e});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [14:0] a, input logic [7:0] e);
      REQ      = 1'b1;
      REQ_ADDR = a;
      exp_q.push_back(e);
      tick();
      REQ = 1'b0;
   endtask

   // Counts negedges with strobes low, stopping at the first negedge with CEn high.
   task automatic count_low(output int n, input logic [14:0] a);
      logic ok;
      n  = 0;
      ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ROM_CEn === 1'b1)
            break;
         n++;
         if (ROM_ADDR !== a || ROM_OEn !== 1'b0)
            ok = 1'b0;
      end
      check("addr_stable_strobes", {31'd0, ok}, 32'd1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60; i++) begin
         if (BUSY === 1'b0)
            break;
         @(negedge clk);
      end
      check("busy_timeout", {31'd0, BUSY}, 32'd0);
   endtask

   initial begin
      int n;
      int h;
      int dv0;
      RSTn     = 1'b0;
      REQ      = 1'b0;
      REQ_ADDR = 15'h0;

      // Reset holds everything idle even with REQ toggling.
      for (int i = 0; i < 4; i++) begin
         REQ      = ~REQ;
         REQ_ADDR = 15'h0555;
         @(negedge clk);
         check("rst_busy",   {31'd0, BUSY},    32'd0);
         check("rst_dvalid", {31'd0, DVALID},  32'd0);
         check("rst_dout",   {24'd0, DOUT},    32'd0);
         check("rst_cen",    {31'd0, ROM_CEn}, 32'd1);
         check("rst_oen",    {31'd0, ROM_OEn}, 32'd1);
         check("rst_addr",   {17'd0, ROM_ADDR}, 32'd0);
      end
      REQ  = 1'b0;
      RSTn = 1'b1;
      tick();
      tick();

      // Single read of 0x1234.
      issue(15'h1234, 8'hA5);
      count_low(n, 15'h1234);
      check("single_low_cycles", n, 4);
      check("single_dvalid", {31'd0, DVALID}, 32'd1);
      check("single_busy_recover", {31'd0, BUSY}, 32'd1);
      @(negedge clk);
      check("single_busy_done", {31'd0, BUSY}, 32'd0);
      check("single_dvalid_pulse", {31'd0, DVALID}, 32'd0);
      check("single_dout_hold", {24'd0, DOUT}, 32'hA5);
      tick();

      // REQ held high across two accesses.
      REQ      = 1'b1;
      REQ_ADDR = 15'h0001;
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      tick();
      REQ_ADDR = 15'h0002;
      count_low(n, 15'h0001);
      check("b2b_first_low", n, 4);
      h = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ROM_CEn === 1'b0)
            break;
         h++;
      end
      check("b2b_high_gap", h, 2);
      check("b2b_second_addr", {17'd0, ROM_ADDR}, 32'h0002);
      REQ = 1'b0;
      count_low(n, 15'h0002);
      check("b2b_second_low_rest", n, 3);
      wait_idle();
      tick();

      // Request during BUSY is dropped.
      dv0 = dv_count;
      issue(15'h1000, 8'h3C);
      tick();
      REQ      = 1'b1;
      REQ_ADDR = 15'h7FFF;
      tick();
      REQ = 1'b0;
      check("drop_addr_busy", {17'd0, ROM_ADDR}, 32'h1000);
      wait_idle();
      repeat (3) tick();
      check("drop_one_dvalid", dv_count - dv0, 1);
      check("drop_addr_hold", {17'd0, ROM_ADDR}, 32'h1000);

      // Reset two edges into an access aborts it.
      dv0      = dv_count;
      REQ      = 1'b1;
      REQ_ADDR = 15'h0200;
      tick();
      REQ = 1'b0;
      tick();
      @(posedge clk);
      #1;
      RSTn = 1'b0;
      #1;
      check("abort_cen", {31'd0, ROM_CEn}, 32'd1);
      check("abort_oen", {31'd0, ROM_OEn}, 32'd1);
      check("abort_busy", {31'd0, BUSY}, 32'd0);
      repeat (2) tick();
      @(negedge clk);
      RSTn = 1'b1;
      repeat (6) tick();
      check("abort_no_dvalid", dv_count - dv0, 0);
      issue(15'h0001, 8'h11);
      count_low(n, 15'h0001);
      check("after_abort_low", n, 4);
      wait_idle();
      tick();
      check("after_abort_dvalid", dv_count - dv0, 1);

`ifdef ROM_READER_CACHE_EN
      issue(15'h0100, 8'h5A);
      wait_idle();
      tick();
      issue(15'h0100, 8'h5A);
      @(negedge clk);
      check("hit_dvalid", {31'd0, DVALID}, 32'd1);
      check("hit_cen", {31'd0, ROM_CEn}, 32'd1);
      check("hit_busy", {31'd0, BUSY}, 32'd0);
      tick();
      issue(15'h0101, 8'hC3);
      count_low(n, 15'h0101);
      check("miss_low_cycles", n, 4);
      wait_idle();
      tick();
`endif

      repeat (3) tick();
      check("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
